// File: rtl/result_checker_pkg.sv
// ============================================================================
// Module      : checker_pkg
// Description : Shared types, error codes and expected-result tables for the
//               writeback result checker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package checker_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_PASS = 2'b10,
      ST_FAIL = 2'b11
   } state_t;

   localparam logic [1:0] ERR_NONE     = 2'b00;
   localparam logic [1:0] ERR_MISMATCH = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
   localparam logic [1:0] ERR_RESERVED = 2'b11;

   localparam logic [1:0] c_test_reserved = 2'b11;

   localparam logic [4:0] c_len_t0 = 5'd4;
   localparam logic [4:0] c_len_t1 = 5'd3;
   localparam logic [4:0] c_len_t2 = 5'd6;

   function automatic logic [4:0] exp_length(input logic [1:0] t);
      case (t)
         2'b00:   return c_len_t0;
         2'b01:   return c_len_t1;
         2'b10:   return c_len_t2;
         default: return 5'd0;
      endcase
   endfunction

   // Entries past a test's length read as zero; the FSM never reaches them.
   function automatic logic [15:0] exp_value(input logic [1:0] t, input logic [3:0] i);
      case ({t, i})
         6'b00_0000: return 16'h0005;
         6'b00_0001: return 16'h000A;
         6'b00_0010: return 16'h000F;
         6'b00_0011: return 16'h0014;
         6'b01_0000: return 16'h0001;
         6'b01_0001: return 16'h0002;
         6'b01_0010: return 16'h0003;
         6'b10_0000: return 16'h0003;
         6'b10_0001: return 16'h0007;
         6'b10_0010: return 16'h000A;
         6'b10_0011: return 16'h0004;
         6'b10_0100: return 16'hFFF9;
         6'b10_0101: return 16'h0000;
         default:    return 16'h0000;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/result_checker_rom.sv
// ============================================================================
// Module      : result_rom
// Description : Combinational lookup of expected result and sequence length.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module result_rom
   import checker_pkg::*;
#(
   parameter int CNT_W = 4
) (
   input  logic [1:0]       test,
   input  logic [CNT_W-1:0] idx,
   output logic [15:0]      exp_data,
   output logic [CNT_W:0]   exp_len
);

   always_comb begin
      exp_data = exp_value(test, 4'(idx));
      exp_len  = (CNT_W+1)'(exp_length(test));
   end

endmodule

`default_nettype wire

// File: rtl/result_checker.sv
// ============================================================================
// Module      : result_checker
// Description : In-order compare of retired writeback results against a
//               selected expected sequence, with sticky pass/fail verdict.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module result_checker
   import checker_pkg::*;
#(
   parameter int TIMEOUT = 1024,
   parameter int CNT_W   = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [1:0]       test,
   input  logic             wb_valid,
   input  logic [15:0]      wb_data,
   output logic             done,
   output logic             pass,
   output logic             fail,
   output logic [1:0]       err_code,
   output logic [CNT_W-1:0] err_index,
   output logic [15:0]      err_data,
   output logic [CNT_W-1:0] match_count
);

   localparam int TMO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TMO_W-1:0] c_tmo_max = TMO_W'(TIMEOUT - 1);

   state_t           r_state;
   logic [1:0]       r_test_q;
   logic [CNT_W:0]   r_exp_len;
   logic [CNT_W-1:0] r_idx;
   logic [TMO_W-1:0] r_tmo;

   logic [1:0]       w_rom_test;
   logic [15:0]      w_exp_data;
   logic [CNT_W:0]   w_exp_len;
   logic             w_last;

   // The live select is only looked at while IDLE loads the length.
   assign w_rom_test = (r_state == ST_IDLE) ? test : r_test_q;
   assign w_last     = (({1'b0, r_idx} + (CNT_W+1)'(1)) == r_exp_len);
   assign match_count = r_idx;

   result_rom #(
      .CNT_W (CNT_W)
   ) u_rom (
      .test     (w_rom_test),
      .idx      (r_idx),
      .exp_data (w_exp_data),
      .exp_len  (w_exp_len)
   );

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= ST_IDLE;
         r_test_q  <= 2'b00;
         r_exp_len <= '0;
         r_idx     <= '0;
         r_tmo     <= '0;
         done      <= 1'b0;
         pass      <= 1'b0;
         fail      <= 1'b0;
         err_code  <= ERR_NONE;
         err_index <= '0;
         err_data  <= 16'h0000;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_test_q  <= test;
               r_exp_len <= w_exp_len;
               if (test == c_test_reserved) begin
                  r_state  <= ST_FAIL;
                  fail     <= 1'b1;
                  done     <= 1'b1;
                  err_code <= ERR_RESERVED;
               end else begin
                  r_state <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (wb_valid) begin
                  if (wb_data == w_exp_data) begin
                     r_idx <= r_idx + CNT_W'(1);
                     r_tmo <= '0;
                     if (w_last) begin
                        r_state <= ST_PASS;
                        pass    <= 1'b1;
                        done    <= 1'b1;
                     end
                  end else begin
                     r_state   <= ST_FAIL;
                     fail      <= 1'b1;
                     done      <= 1'b1;
                     err_code  <= ERR_MISMATCH;
                     err_index <= r_idx;
                     err_data  <= wb_data;
                  end
               end else if (r_tmo == c_tmo_max) begin
                  r_state  <= ST_FAIL;
                  fail     <= 1'b1;
                  done     <= 1'b1;
                  err_code <= ERR_TIMEOUT;
               end else begin
                  r_tmo <= r_tmo + TMO_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_result_checker.sv
// ============================================================================
// Module      : tb_result_checker
// Description : Directed self-checking bench for result_checker.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_result_checker;

   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             reset;
   logic [1:0]       test;
   logic             wb_valid;
   logic [15:0]      wb_data;
   logic             done;
   logic             pass;
   logic             fail;
   logic [1:0]       err_code;
   logic [CNT_W-1:0] err_index;
   logic [15:0]      err_data;
   logic [CNT_W-1:0] match_count;

   int ntests = 0;
   int nfail  = 0;

   result_checker #(
      .TIMEOUT (16),
      .CNT_W   (CNT_W)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .test        (test),
      .wb_valid    (wb_valid),
      .wb_data     (wb_data),
      .done        (done),
      .pass        (pass),
      .fail        (fail),
      .err_code    (err_code),
      .err_index   (err_index),
      .err_data    (err_data),
      .match_count (match_count)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic start(input logic [1:0] t);
      wb_valid = 1'b0;
      wb_data  = 16'h0000;
      reset    = 1'b1;
      test     = t;
      tick();
      reset    = 1'b0;
   endtask

   task automatic feed(input logic [15:0] d);
      wb_valid = 1'b1;
      wb_data  = d;
      tick();
      wb_valid = 1'b0;
   endtask

   task automatic check_all_clear(input string tag);
      check({tag, "_done"}, 32'(done), 32'd0);
      check({tag, "_pass"}, 32'(pass), 32'd0);
      check({tag, "_fail"}, 32'(fail), 32'd0);
      check({tag, "_code"}, 32'(err_code), 32'd0);
      check({tag, "_eidx"}, 32'(err_index), 32'd0);
      check({tag, "_edat"}, 32'(err_data), 32'd0);
      check({tag, "_mcnt"}, 32'(match_count), 32'd0);
   endtask

   initial begin
      reset    = 1'b1;
      test     = 2'b10;
      wb_valid = 1'b0;
      wb_data  = 16'h0000;
      #2;
      check_all_clear("reset");

      // Test 10: clean back-to-back run including the 0xFFF9 bit pattern
      start(2'b10);
      tick();
      wb_valid = 1'b1;
      wb_data = 16'h0003; tick();
      wb_data = 16'h0007; tick();
      wb_data = 16'h000A; tick();
      wb_data = 16'h0004; tick();
      wb_data = 16'hFFF9; tick();
      check("t10_pass_early", 32'(pass), 32'd0);
      check("t10_mcnt5", 32'(match_count), 32'd5);
      wb_data = 16'h0000; tick();
      wb_valid = 1'b0;
      check("t10_pass", 32'(pass), 32'd1);
      check("t10_done", 32'(done), 32'd1);
      check("t10_fail", 32'(fail), 32'd0);
      check("t10_mcnt", 32'(match_count), 32'd6);
      check("t10_code", 32'(err_code), 32'd0);

      // Test 00: mismatch on the second result
      start(2'b00);
      tick();
      feed(16'h0005);
      check("mm_fail_early", 32'(fail), 32'd0);
      feed(16'h000B);
      check("mm_fail", 32'(fail), 32'd1);
      check("mm_done", 32'(done), 32'd1);
      check("mm_pass", 32'(pass), 32'd0);
      check("mm_code", 32'(err_code), 32'd1);
      check("mm_eidx", 32'(err_index), 32'd1);
      check("mm_edat", 32'(err_data), 32'h000B);
      check("mm_mcnt", 32'(match_count), 32'd1);

      // Test 01: timeout 16 cycles after the accepted result
      start(2'b01);
      tick();
      feed(16'h0001);
      for (int i = 0; i < 14; i++) tick();
      check("to_fail_early", 32'(fail), 32'd0);
      tick();
      check("to_fail_edge", 32'(fail), 32'd0);
      tick();
      check("to_fail", 32'(fail), 32'd1);
      check("to_code", 32'(err_code), 32'd2);
      check("to_mcnt", 32'(match_count), 32'd1);

      // Timeout counted from RUN entry with no result at all
      start(2'b00);
      tick();
      for (int i = 0; i < 15; i++) tick();
      check("to0_fail_early", 32'(fail), 32'd0);
      tick();
      check("to0_fail", 32'(fail), 32'd1);
      check("to0_code", 32'(err_code), 32'd2);

      // Reserved test select
      start(2'b11);
      check("rsv_fail_idle", 32'(fail), 32'd0);
      tick();
      check("rsv_fail", 32'(fail), 32'd1);
      check("rsv_done", 32'(done), 32'd1);
      check("rsv_code", 32'(err_code), 32'd3);
      check("rsv_mcnt", 32'(match_count), 32'd0);

      // Reset mid-run clears immediately, then rerun test 01 to pass
      start(2'b00);
      tick();
      feed(16'h0005);
      feed(16'h000A);
      check("mid_mcnt", 32'(match_count), 32'd2);
      reset = 1'b1;
      #1;
      check_all_clear("midrst");
      test = 2'b01;
      tick();
      reset = 1'b0;
      tick();
      feed(16'h0001);
      feed(16'h0002);
      feed(16'h0003);
      check("t01_pass", 32'(pass), 32'd1);
      check("t01_mcnt", 32'(match_count), 32'd3);

      // Sticky verdict: extra result after pass is ignored
      feed(16'h1234);
      tick();
      check("sticky_pass", 32'(pass), 32'd1);
      check("sticky_fail", 32'(fail), 32'd0);
      check("sticky_mcnt", 32'(match_count), 32'd3);
      check("sticky_code", 32'(err_code), 32'd0);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/result_checker.md
# result_checker

Self-checking sink for the pipelined processor's writeback stream. Sits beside the processor core in `top` and consumes each retired 16-bit result. It compares the results in order against an expected sequence chosen by the `test` select and reports a sticky pass/fail verdict. This lets the same test programs run unattended in simulation and on hardware.

## Interface

**Parameters**
- `TIMEOUT`, default 1024: idle cycles in RUN with no `wb_valid` before declaring failure.
- `CNT_W`, default 4: width of the result index counter (max 16 expected entries per test).

**Ports**
- `clk`, input, 1: single clock, rising edge.
- `reset`, input, 1: asynchronous, active-high reset.
- `test`, input, 2: test program select; sampled in IDLE only.
- `wb_valid`, input, 1: a result retired this cycle.
- `wb_data`, input, 16: retired result value.
- `done`, output, 1: verdict available; sticky until reset.
- `pass`, output, 1: all expected results matched; sticky.
- `fail`, output, 1: mismatch, timeout or reserved test; sticky.
- `err_code`, output, 2: failure cause. 00 none, 01 mismatch, 10 timeout, 11 reserved test.
- `err_index`, output, CNT_W: index of the first mismatching result.
- `err_data`, output, 16: `wb_data` value that mismatched.
- `match_count`, output, CNT_W: number of results matched so far.

## Operation

- **FSM states:** IDLE, RUN, PASS, FAIL. Reset enters IDLE.
- **IDLE** (exactly one cycle after reset deasserts):
  - Latch `test` into `test_q`.
  - Load `exp_len` from the ROM.
  - If `test` is 2'b11, go to FAIL with `err_code`=11. Otherwise go to RUN.
  - `wb_valid` in IDLE is ignored.
- **RUN:**
  - On `wb_valid`, compare `wb_data` with `exp[test_q][idx]`.
  - Equal:
    - Increment `idx` and `match_count`.
    - Clear the timeout counter.
    - If `idx+1 == exp_len`, go to PASS.
  - Not equal:
    - Capture `err_index`=`idx` and `err_data`=`wb_data`.
    - Set `err_code`=01 and go to FAIL.
  - No `wb_valid`: increment the timeout counter. When it reaches `TIMEOUT-1`, set `err_code`=10 and go to FAIL.
- **PASS / FAIL:** terminal states; `wb_valid` is ignored. Only `reset` leaves them.
- **Expected sequences:** held in the ROM.
  - Test 00: 0x0005, 0x000A, 0x000F, 0x0014 (length 4).
  - Test 01: 0x0001, 0x0002, 0x0003 (length 3).
  - Test 10: 0x0003, 0x0007, 0x000A, 0x0004, 0xFFF9, 0x0000 (length 6).
  - Test 11: reserved.
- **Compare rule:** the full 16-bit compare is exact, with no masking. Wrap-around values such as 0xFFF9 are plain bit patterns.

## Timing

- **Reset values:**
  - `done`, `pass`, `fail` = 0.
  - `err_code` = 00, `err_index` = 0, `err_data` = 0x0000, `match_count` = 0.
  - `idx` and the timeout counter = 0.
- All outputs are registered. A verdict appears on the cycle after the deciding `wb_valid` edge (1-cycle latency).
- `done` rises on the same cycle as `pass` or `fail`. `pass` and `fail` are never both 1.
- A timeout asserts `fail` exactly `TIMEOUT` cycles after the last accepted result, or after RUN entry if no result has been accepted.
- Back-to-back `wb_valid` on every cycle is supported with no stall. The checker has no backpressure.
- **Reset mid-run:** asynchronously clears all state and outputs. On release, `test` is resampled in IDLE.

## Structure

- **Package `checker_pkg`:**
  - FSM state enum.
  - `err_code` constants: ERR_NONE, ERR_MISMATCH, ERR_TIMEOUT, ERR_RESERVED.
  - Per-test lengths and expected constants.
- **Sub-module `result_rom`:** combinational lookup. Inputs are `test` and `idx`; outputs are `exp_data[15:0]` and `exp_len`. This keeps test content separate from the FSM.
- **Top-level `result_checker`:** FSM, index counter, timeout counter and error capture registers.

## Test plan

- **Test 10 clean run:** `test`=10, reset released, then feed 0x0003, 0x0007, 0x000A, 0x0004, 0xFFF9, 0x0000 on consecutive cycles. Expect `pass`=1, `done`=1, `match_count`=6, `err_code`=00, one cycle after the last result.
- **Mismatch:** `test`=00, feed 0x0005, 0x000B. Expect `fail`=1, `err_code`=01, `err_index`=1, `err_data`=0x000B, `match_count`=1.
- **Timeout:** `test`=01, `TIMEOUT`=16, feed 0x0001 then no `wb_valid`. Expect `fail`=1 and `err_code`=10 exactly 16 cycles after the accepted result.
- **Reserved test:** `test`=11. Expect `fail`=1 and `err_code`=11 on the second cycle after reset release, with `match_count`=0.
- **Sticky verdict:** after the test 01 pass, feed a further 0x1234. Outputs must stay unchanged (`pass`=1, `fail`=0).
- **Reset mid-run:** `test`=00, feed 2 correct results, assert `reset`. Expect all outputs to clear immediately. Then rerun with `test`=01 and reach `pass` with `match_count`=3.
